bch_dec_ctrl: RTL and testbench

- Top-level sequencer for the BCH decoder datapath.
- Owns the set/ready input handshake and generates beat addresses into the received-word store.
- Fires one-cycle start pulses to the syndrome, Berlekamp-Massey and Chien units in turn, then buffers the error locations Chien reports.
- Streams the locations out on finish/odata, or a single sentinel beat when the word is clean or uncorrectable.

---
 rtl/bch_dec_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_bch_dec_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_ctrl.sv
// Top-level BCH decoder sequencer: loads the received word, steps through syndrome,
// Berlekamp-Massey and Chien units, and streams buffered error locations.
module bch_dec_ctrl #(
  parameter int unsigned            ADDR_W   = 7,
  parameter int unsigned            LOC_W    = 10,
  parameter int unsigned            MAX_ERR  = 4,
  parameter logic [LOC_W-1:0]       SENTINEL = 10'd1023
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set,
  input  logic              mode,
  input  logic [1:0]        code,
  output logic              ready,
  output logic              load_we,
  output logic [ADDR_W-1:0] load_addr,
  output logic              dec_mode,
  output logic [1:0]        dec_code,
  output logic              syn_start,
  input  logic              syn_done,
  input  logic              syn_zero,
  output logic              ber_start,
  input  logic              ber_done,
  input  logic              ber_fail,
  input  logic [2:0]        ber_deg,
  output logic              chi_start,
  input  logic              chi_valid,
  input  logic [LOC_W-1:0]  chi_loc,
  input  logic              chi_done,
  output logic              finish,
  output logic [LOC_W-1:0]  odata
);

  localparam int unsigned CNT_W = $clog2(MAX_ERR + 1);
  localparam int unsigned IDX_W = (MAX_ERR > 1) ? $clog2(MAX_ERR) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SYN, BER, CHI, OUT} state_t;

  state_t             state, state_n;
  logic               ready_n, mode_n, syn_start_n, ber_start_n, chi_start_n;
  logic               finish_n, err_flag, err_n, go_out;
  logic [1:0]         code_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [LOC_W-1:0]   odata_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [IDX_W-1:0]   out_idx, out_idx_n;
  logic [2:0]         deg_q, deg_n;
  logic [LOC_W-1:0]   buffer   [MAX_ERR];
  logic [LOC_W-1:0]   buffer_n [MAX_ERR];
  int unsigned        t_max;

  function automatic logic [ADDR_W-1:0] last_beat(input logic [1:0] c);
    case (c)
      2'd1:    last_beat = ADDR_W'(7);
      2'd2:    last_beat = ADDR_W'(31);
      default: last_beat = ADDR_W'(127);
    endcase
  endfunction

  assign t_max = (dec_code == 2'd3) ? 32'd4 : 32'd2;

  always_comb begin
    state_n     = state;
    ready_n     = ready;
    addr_n      = load_addr;
    mode_n      = dec_mode;
    code_n      = dec_code;
    syn_start_n = 1'b0;
    ber_start_n = 1'b0;
    chi_start_n = 1'b0;
    finish_n    = finish;
    odata_n     = odata;
    count_n     = count;
    err_n       = err_flag;
    deg_n       = deg_q;
    out_idx_n   = out_idx;
    buffer_n    = buffer;
    go_out      = 1'b0;

    case (state)
      IDLE: begin
        if (set) begin
          mode_n  = mode;
          code_n  = (code == 2'd0) ? 2'd3 : code;
          addr_n  = last_beat(code_n);
          count_n = '0;
          err_n   = 1'b0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (!ready) begin
          ready_n = 1'b1;
        end else if (load_addr == '0) begin
          ready_n     = 1'b0;
          syn_start_n = 1'b1;
          state_n     = SYN;
        end else begin
          addr_n = load_addr - ADDR_W'(1);
        end
      end
      SYN: begin
        if (syn_done) begin
          if (syn_zero) begin
            go_out = 1'b1;
          end else begin
            ber_start_n = 1'b1;
            state_n     = BER;
          end
        end
      end
      BER: begin
        if (ber_done) begin
          deg_n = ber_deg;
          if (ber_fail || ber_deg == 3'd0 || 32'(ber_deg) > t_max) begin
            err_n  = 1'b1;
            go_out = 1'b1;
          end else begin
            chi_start_n = 1'b1;
            state_n     = CHI;
          end
        end
      end
      CHI: begin
        if (chi_valid) begin
          if (32'(count) < MAX_ERR) begin
            buffer_n[count[IDX_W-1:0]] = chi_loc;
            count_n = count + CNT_W'(1);
          end else begin
            err_n = 1'b1;
          end
        end
        // a valid arriving with done is already folded into count_n here
        if (chi_done) begin
          if (32'(count_n) != 32'(deg_q)) err_n = 1'b1;
          go_out = 1'b1;
        end
      end
      OUT: begin
        if (err_flag || count == '0 || 32'(out_idx) + 32'd1 >= 32'(count)) begin
          finish_n = 1'b0;
          odata_n  = '0;
          state_n  = IDLE;
        end else begin
          out_idx_n = out_idx + IDX_W'(1);
          odata_n   = buffer[out_idx + IDX_W'(1)];
        end
      end
      default: state_n = IDLE;
    endcase

    // first output beat is registered on the same edge that leaves SYN/BER/CHI
    if (go_out) begin
      state_n   = OUT;
      finish_n  = 1'b1;
      out_idx_n = '0;
      odata_n   = (err_n || count_n == '0) ? SENTINEL : buffer_n[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ready     <= 1'b0;
      load_we   <= 1'b0;
      load_addr <= '0;
      dec_mode  <= 1'b0;
      dec_code  <= '0;
      syn_start <= 1'b0;
      ber_start <= 1'b0;
      chi_start <= 1'b0;
      finish    <= 1'b0;
      odata     <= '0;
      count     <= '0;
      err_flag  <= 1'b0;
      deg_q     <= '0;
      out_idx   <= '0;
      for (int unsigned i = 0; i < MAX_ERR; i++) buffer[i] <= '0;
    end else begin
      state     <= state_n;
      ready     <= ready_n;
      load_we   <= ready_n;
      load_addr <= addr_n;
      dec_mode  <= mode_n;
      dec_code  <= code_n;
      syn_start <= syn_start_n;
      ber_start <= ber_start_n;
      chi_start <= chi_start_n;
      finish    <= finish_n;
      odata     <= odata_n;
      count     <= count_n;
      err_flag  <= err_n;
      deg_q     <= deg_n;
      out_idx   <= out_idx_n;
      for (int unsigned i = 0; i < MAX_ERR; i++) buffer[i] <= buffer_n[i];
    end
  end

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Directed bench for bch_dec_ctrl: emulates the datapath units and checks the
// load handshake, start pulses and the finish/odata stream.
module tb_bch_dec_ctrl;

  logic       clk = 1'b0;
  logic       rstn, set, mode;
  logic [1:0] code;
  logic       ready, load_we, dec_mode;
  logic [6:0] load_addr;
  logic [1:0] dec_code;
  logic       syn_start, syn_done, syn_zero;
  logic       ber_start, ber_done, ber_fail;
  logic [2:0] ber_deg;
  logic       chi_start, chi_valid, chi_done;
  logic [9:0] chi_loc;
  logic       finish;
  logic [9:0] odata;

  int n_checks = 0;
  int n_err    = 0;
  int locs[$];
  int exp_q[$];

  always #5 clk = ~clk;

  bch_dec_ctrl #(.ADDR_W(7), .LOC_W(10), .MAX_ERR(4), .SENTINEL(10'd1023)) dut (
    .clk(clk), .rstn(rstn), .set(set), .mode(mode), .code(code),
    .ready(ready), .load_we(load_we), .load_addr(load_addr),
    .dec_mode(dec_mode), .dec_code(dec_code),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero),
    .ber_start(ber_start), .ber_done(ber_done), .ber_fail(ber_fail), .ber_deg(ber_deg),
    .chi_start(chi_start), .chi_valid(chi_valid), .chi_loc(chi_loc), .chi_done(chi_done),
    .finish(finish), .odata(odata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, ready, load_we, load_addr, dec_mode, dec_code,
            syn_start, ber_start, chi_start, finish, odata};
  endfunction

  // set pulse, then the full load window; ends on the negedge where syn_start is high
  task automatic start_load(input logic [1:0] c, input logic m, input int beats, input bit poke);
    int bad = 0;
    @(negedge clk);
    set = 1'b1; code = c; mode = m;
    @(negedge clk);
    set = 1'b0; code = 2'd1; mode = ~m;
    check("ready_after_set", ready, 0);
    check("addr_after_set", load_addr, beats - 1);
    check("dec_code", dec_code, (c == 2'd0) ? 3 : c);
    check("dec_mode", dec_mode, m);
    for (int i = 0; i < beats; i++) begin
      @(negedge clk);
      if (ready !== 1'b1 || load_we !== 1'b1) bad++;
      if (load_addr !== 7'(beats - 1 - i)) bad++;
      if (syn_start !== 1'b0) bad++;
      set = (poke && i == 10) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    set = 1'b0;
    check("load_seq_errors", bad, 0);
    check("ready_drop", {ready, load_we}, 0);
    check("syn_start_pulse", syn_start, 1);
  endtask

  task automatic collect(input string tag);
    for (int j = 0; j < exp_q.size(); j++) begin
      check({tag, "_finish"}, finish, 1);
      check({tag, "_odata"}, odata, exp_q[j]);
      @(negedge clk);
    end
    check({tag, "_end"}, {finish, odata}, 0);
  endtask

  task automatic run_case(input string tag, input logic [1:0] c, input logic m, input int beats,
                          input bit poke, input bit zero, input bit fail, input logic [2:0] deg,
                          input bit ber_abort, input bit coinc);
    start_load(c, m, beats, poke);
    @(negedge clk);
    check({tag, "_syn_once"}, syn_start, 0);
    repeat (3) @(negedge clk);
    syn_done = 1'b1; syn_zero = zero;
    @(negedge clk);
    syn_done = 1'b0; syn_zero = 1'b0;
    if (zero) begin
      check({tag, "_no_ber"}, ber_start, 0);
      collect(tag);
      return;
    end
    check({tag, "_ber_start"}, ber_start, 1);
    @(negedge clk);
    check({tag, "_ber_once"}, ber_start, 0);
    ber_done = 1'b1; ber_fail = fail; ber_deg = deg;
    @(negedge clk);
    ber_done = 1'b0; ber_fail = 1'b0; ber_deg = 3'd0;
    if (ber_abort) begin
      check({tag, "_no_chi"}, chi_start, 0);
      collect(tag);
      return;
    end
    check({tag, "_chi_start"}, chi_start, 1);
    for (int k = 0; k < locs.size(); k++) begin
      chi_valid = 1'b1;
      chi_loc   = 10'(locs[k]);
      chi_done  = (coinc && k == locs.size() - 1);
      @(negedge clk);
    end
    chi_valid = 1'b0;
    if (!coinc) begin
      chi_done = 1'b1;
      @(negedge clk);
    end
    chi_done = 1'b0;
    collect(tag);
  endtask

  initial begin
    rstn = 1'b0; set = 1'b0; mode = 1'b0; code = 2'd0;
    syn_done = 1'b0; syn_zero = 1'b0; ber_done = 1'b0; ber_fail = 1'b0; ber_deg = 3'd0;
    chi_valid = 1'b0; chi_loc = '0; chi_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rstn = 1'b1;

    // stray done/valid in IDLE must not start anything
    @(negedge clk);
    syn_done = 1'b1; chi_done = 1'b1; chi_valid = 1'b1; ber_done = 1'b1;
    @(negedge clk);
    syn_done = 1'b0; chi_done = 1'b0; chi_valid = 1'b0; ber_done = 1'b0;
    @(negedge clk);
    check("idle_ignores", all_outs(), 0);

    locs = {};            exp_q = {1023};
    run_case("clean63", 2'd1, 1'b0, 8, 0, 1, 0, 3'd0, 0, 0);

    locs = {200, 17};     exp_q = {200, 17};
    run_case("two255", 2'd2, 1'b1, 32, 0, 0, 0, 3'd2, 0, 0);

    locs = {900, 512, 33, 0}; exp_q = {900, 512, 33, 0};
    run_case("four1023", 2'd3, 1'b0, 128, 0, 0, 0, 3'd4, 0, 1);

    locs = {};            exp_q = {1023};
    run_case("berfail", 2'd2, 1'b0, 32, 0, 0, 1, 3'd2, 1, 0);
    run_case("deg_gt_t", 2'd2, 1'b0, 32, 0, 0, 0, 3'd3, 1, 0);
    run_case("deg_zero", 2'd1, 1'b0, 8, 0, 0, 0, 3'd0, 1, 0);

    locs = {5, 6};        exp_q = {1023};
    run_case("too_few", 2'd3, 1'b1, 128, 0, 0, 0, 3'd3, 0, 0);

    locs = {1, 2, 3, 4, 5}; exp_q = {1023};
    run_case("overflow", 2'd3, 1'b0, 128, 0, 0, 0, 3'd4, 0, 0);

    locs = {300};         exp_q = {300};
    run_case("one_coinc", 2'd1, 1'b1, 8, 0, 0, 0, 3'd1, 0, 1);

    // code 0 with a second set mid-load, then asynchronous reset while in SYN
    start_load(2'd0, 1'b1, 128, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", all_outs(), 0);
    @(negedge clk);
    rstn = 1'b1;
    locs = {};            exp_q = {1023};
    run_case("after_rst", 2'd0, 1'b0, 128, 0, 1, 0, 3'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
